fbmem_responder: RTL and testbench

Memory-side responder for the FBCPU memory bus: a 64-word x 10-bit synchronous RAM that answers FBCPU address/data/write-enable requests on one port and exposes a second, handshaked host port for burst loading and dumping program/data images. It sits beside FBCPU in the top level and in benches, so a host can preload programs and read back results without hierarchical memory access.

---
 rtl/fbmem_pkg.sv | 14 +
 rtl/fbmem_dpram.sv | 57 +++++
 rtl/fbmem_responder.sv | 122 ++++++++++++
 tb/tb_fbmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fbmem_pkg.sv
// Shared constants for the FBCPU memory responder: default geometry and host FSM state encoding.
package fbmem_pkg;

    localparam int unsigned FBMEM_ADDR_W = 6;
    localparam int unsigned FBMEM_DATA_W = 10;
    localparam int unsigned FBMEM_DEPTH  = 64;

    typedef logic [1:0] fbmem_state_t;

    localparam fbmem_state_t ST_IDLE  = 2'd0;
    localparam fbmem_state_t ST_WRITE = 2'd1;
    localparam fbmem_state_t ST_READ  = 2'd2;

endpackage

// File: rtl/fbmem_dpram.sv
// Two-port synchronous RAM: port A (CPU) is write-first and wins same-address write collisions,
// port B (host) has a read-enabled output register that holds its word until the next read.
module fbmem_dpram
    import fbmem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = FBMEM_ADDR_W,
    parameter int unsigned DATA_WIDTH    = FBMEM_DATA_W,
    parameter int unsigned DEPTH         = FBMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    input  logic                     b_we,
    input  logic                     b_re,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic [DATA_WIDTH-1:0]    b_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  b_write_en;

    always_comb begin
        b_write_en = b_we && !(a_we && (a_addr == b_addr));
        a_rdata_d  = a_we ? a_wdata : mem[a_addr];
        b_rdata_d  = b_re ? mem[b_addr] : b_rdata_q;
    end

    // Array is never reset; cross-port reads see pre-write contents through NBA ordering.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        if (b_write_en) begin
            mem[b_addr] <= b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/fbmem_responder.sv
// FBCPU memory responder: CPU port served every cycle, plus a handshaked host burst port
// for loading and dumping images.
module fbmem_responder
    import fbmem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = FBMEM_ADDR_W,
    parameter int unsigned DATA_WIDTH    = FBMEM_DATA_W,
    parameter int unsigned DEPTH         = FBMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ADDRESS_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
    output logic [DATA_WIDTH-1:0]    o_ram_data_out,
    input  logic                     h_req_valid,
    output logic                     h_req_ready,
    input  logic                     h_req_wr,
    input  logic [ADDRESS_WIDTH-1:0] h_req_addr,
    input  logic [ADDRESS_WIDTH-1:0] h_req_len,
    input  logic                     h_wdata_valid,
    output logic                     h_wdata_ready,
    input  logic [DATA_WIDTH-1:0]    h_wdata,
    output logic                     h_rdata_valid,
    input  logic                     h_rdata_ready,
    output logic [DATA_WIDTH-1:0]    h_rdata,
    output logic                     h_busy
);

    localparam logic [ADDRESS_WIDTH:0] REM_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    fbmem_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
    logic                     rvalid_q, rvalid_d;
    logic                     host_we;
    logic                     rd_issue;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        rvalid_d = rvalid_q;
        host_we  = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (h_req_valid) begin
                    ptr_d   = h_req_addr;
                    rem_d   = {1'b0, h_req_len} + REM_ONE;
                    state_d = h_req_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (h_wdata_valid) begin
                    host_we = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                // rem_q counts words not yet issued; the output slot refills as it drains.
                rd_issue = (rem_q != '0) && (!rvalid_q || h_rdata_ready);
                if (rd_issue) begin
                    ptr_d    = ptr_q + 1'b1;
                    rem_d    = rem_q - REM_ONE;
                    rvalid_d = 1'b1;
                end else if (h_rdata_ready) begin
                    rvalid_d = 1'b0;
                    if (rvalid_q && (rem_q == '0)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            rvalid_q <= rvalid_d;
        end
    end

    fbmem_dpram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst),
        .a_we   (i_we),
        .a_addr (i_addr),
        .a_wdata(i_ram_data_in),
        .a_rdata(o_ram_data_out),
        .b_we   (host_we),
        .b_re   (rd_issue),
        .b_addr (ptr_q),
        .b_wdata(h_wdata),
        .b_rdata(h_rdata)
    );

    assign h_req_ready   = rst && (state_q == ST_IDLE);
    assign h_wdata_ready = (state_q == ST_WRITE);
    assign h_rdata_valid = rvalid_q;
    assign h_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fbmem_responder.sv
// Directed bench for fbmem_responder: inputs change and outputs are checked on the falling edge.
module tb_fbmem_responder;
    import fbmem_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_we = 1'b0;
    logic [5:0] i_addr = '0;
    logic [9:0] i_ram_data_in = '0;
    logic [9:0] o_ram_data_out;
    logic       h_req_valid = 1'b0;
    logic       h_req_ready;
    logic       h_req_wr = 1'b0;
    logic [5:0] h_req_addr = '0;
    logic [5:0] h_req_len = '0;
    logic       h_wdata_valid = 1'b0;
    logic       h_wdata_ready;
    logic [9:0] h_wdata = '0;
    logic       h_rdata_valid;
    logic       h_rdata_ready = 1'b0;
    logic [9:0] h_rdata;
    logic       h_busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] pat = 4'b1001;
    logic [9:0] exp_wrap [4] = '{10'h3E1, 10'h3F2, 10'h003, 10'h014};
    logic [9:0] w;
    int         idx;

    always #5 clk = ~clk;

    fbmem_responder #(
        .ADDRESS_WIDTH(6),
        .DATA_WIDTH   (10),
        .DEPTH        (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_we          (i_we),
        .i_addr        (i_addr),
        .i_ram_data_in (i_ram_data_in),
        .o_ram_data_out(o_ram_data_out),
        .h_req_valid   (h_req_valid),
        .h_req_ready   (h_req_ready),
        .h_req_wr      (h_req_wr),
        .h_req_addr    (h_req_addr),
        .h_req_len     (h_req_len),
        .h_wdata_valid (h_wdata_valid),
        .h_wdata_ready (h_wdata_ready),
        .h_wdata       (h_wdata),
        .h_rdata_valid (h_rdata_valid),
        .h_rdata_ready (h_rdata_ready),
        .h_rdata       (h_rdata),
        .h_busy        (h_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [9:0] d);
        i_we = 1'b1;
        i_addr = a;
        i_ram_data_in = d;
        @(negedge clk);
        i_we = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cpu_out", 16'(o_ram_data_out), 16'h0);
        chk("rst_req_ready", 16'(h_req_ready), 16'h0);
        chk("rst_wdata_ready", 16'(h_wdata_ready), 16'h0);
        chk("rst_rvalid", 16'(h_rdata_valid), 16'h0);
        chk("rst_rdata", 16'(h_rdata), 16'h0);
        chk("rst_busy", 16'(h_busy), 16'h0);
        rst = 1'b1;
        #1;
        chk("idle_req_ready", 16'(h_req_ready), 16'h1);
        @(negedge clk);

        // CPU write-first then read-back
        i_we = 1'b1; i_addr = 6'd52; i_ram_data_in = 10'h155;
        @(negedge clk);
        chk("cpu_write_first", 16'(o_ram_data_out), 16'h155);
        i_we = 1'b0; i_addr = 6'd52;
        @(negedge clk);
        chk("cpu_readback", 16'(o_ram_data_out), 16'h155);

        // Host burst write, gapped data
        h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_addr = 6'd10; h_req_len = 6'd3;
        @(negedge clk);
        h_req_valid = 1'b0;
        chk("hw_busy_rise", 16'(h_busy), 16'h1);
        chk("hw_wdata_ready", 16'(h_wdata_ready), 16'h1);
        for (int k = 0; k < 4; k++) begin
            h_wdata_valid = 1'b1;
            h_wdata = 10'(k + 1);
            @(negedge clk);
            chk("hw_busy", 16'(h_busy), (k == 3) ? 16'h0 : 16'h1);
            h_wdata_valid = 1'b0;
            @(negedge clk);
        end
        for (int a = 10; a < 14; a++) begin
            i_addr = 6'(a);
            @(negedge clk);
            chk("hw_mem", 16'(o_ram_data_out), 16'(a - 9));
        end

        // Host burst read with wrap and backpressure 1,0,0,1
        cpu_write(6'd62, 10'h3E1);
        cpu_write(6'd63, 10'h3F2);
        cpu_write(6'd0, 10'h003);
        cpu_write(6'd1, 10'h014);
        h_req_valid = 1'b1; h_req_wr = 1'b0; h_req_addr = 6'd62; h_req_len = 6'd3;
        @(negedge clk);
        h_req_valid = 1'b0;
        chk("hr_busy_rise", 16'(h_busy), 16'h1);
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            h_rdata_ready = pat[c % 4];
            if (h_rdata_valid) begin
                chk("hr_wrap_data", 16'(h_rdata), 16'(exp_wrap[idx]));
                if (h_rdata_ready) idx++;
            end
            @(negedge clk);
        end
        h_rdata_ready = 1'b0;
        chk("hr_word_count", 16'(idx), 16'd4);
        chk("hr_busy_fall", 16'(h_busy), 16'h0);
        chk("hr_rvalid_fall", 16'(h_rdata_valid), 16'h0);

        // Same-cycle CPU and host write to addr 5
        h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_addr = 6'd5; h_req_len = 6'd0;
        @(negedge clk);
        h_req_valid = 1'b0;
        h_wdata_valid = 1'b1; h_wdata = 10'h3FF;
        i_we = 1'b1; i_addr = 6'd5; i_ram_data_in = 10'h0AA;
        @(negedge clk);
        h_wdata_valid = 1'b0; i_we = 1'b0;
        chk("coll_busy", 16'(h_busy), 16'h0);
        chk("coll_cpu_out", 16'(o_ram_data_out), 16'h0AA);
        @(negedge clk);
        chk("coll_mem5", 16'(o_ram_data_out), 16'h0AA);

        // Reset during word 2 of a 5-word host read
        h_rdata_ready = 1'b1;
        h_req_valid = 1'b1; h_req_wr = 1'b0; h_req_addr = 6'd10; h_req_len = 6'd4;
        @(negedge clk);
        h_req_valid = 1'b0;
        @(negedge clk);
        chk("rr_word1", {5'd0, h_rdata_valid, h_rdata}, {6'h01, 10'h001});
        @(negedge clk);
        chk("rr_word2", {5'd0, h_rdata_valid, h_rdata}, {6'h01, 10'h002});
        rst = 1'b0;
        #1;
        chk("rr_rvalid", 16'(h_rdata_valid), 16'h0);
        chk("rr_busy", 16'(h_busy), 16'h0);
        chk("rr_req_ready_low", 16'(h_req_ready), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rr_req_ready", 16'(h_req_ready), 16'h1);
        i_addr = 6'd11;
        h_req_valid = 1'b1; h_req_addr = 6'd12; h_req_len = 6'd0;
        @(negedge clk);
        h_req_valid = 1'b0;
        chk("rr_mem_kept", 16'(o_ram_data_out), 16'h002);
        @(negedge clk);
        chk("rr_new_req", {5'd0, h_rdata_valid, h_rdata}, {6'h01, 10'h003});
        @(negedge clk);
        chk("rr_new_done", 16'(h_busy), 16'h0);

        // Full 64-word host load and dump
        h_req_valid = 1'b1; h_req_wr = 1'b1; h_req_addr = 6'd0; h_req_len = 6'd63;
        @(negedge clk);
        h_req_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            h_wdata_valid = 1'b1;
            h_wdata = 10'((i * 37 + 5) & 'h3FF);
            @(negedge clk);
        end
        h_wdata_valid = 1'b0;
        chk("load_done", 16'(h_busy), 16'h0);
        i_addr = 6'd52;
        @(negedge clk);
        chk("load_mem52", 16'(o_ram_data_out), 16'((52 * 37 + 5) & 'h3FF));
        h_req_valid = 1'b1; h_req_wr = 1'b0; h_req_addr = 6'd0; h_req_len = 6'd63;
        @(negedge clk);
        h_req_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            w = 10'((i * 37 + 5) & 'h3FF);
            chk("dump_word", {5'd0, h_rdata_valid, h_rdata}, {6'h01, w});
        end
        @(negedge clk);
        chk("dump_done", 16'(h_busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
